// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM:
// opcodes, state codes, ALU/mux selects and the control word.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// State (+ mem_ready) to control word; Moore except FETCH pc/ir load.
// Ports: state, mem_ready in; ctrl out. Macro: MULTICYCLE_CONTROL_ADDI_EN.
module mc_output_decode
  import mc_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        ctrl.pc_write  = mem_ready;
        ctrl.ir_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: state register + next state.
// Ports: clk, rst_n, op, mem_ready in; datapath controls,
// illegal_op, state out. Macro: MULTICYCLE_CONTROL_ADDI_EN.
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    illegal_op = 1'b0;
    unique case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):  state_d = ST_MEMADR;
          (op == OP_R):   state_d = ST_EXEC;
          (op == OP_BEQ): state_d = ST_BRANCH;
          (op == OP_J):   state_d = ST_JUMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
          (op == OP_ADDI): state_d = ST_ADDIEX;
`endif
          default: begin
            state_d    = ST_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      // op only ever holds lw or sw here
      ST_MEMADR: state_d = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  mc_output_decode u_dec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: state walk and control
// word per cycle, memory waits, illegal opcodes, async reset.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d;
  logic       mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write;
  logic       alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [16:0] obs;

  int total;
  int bad;

  // {pcw,pwc,iord,mr,mw,irw,m2r,rdst,rw,asa,asb,aop,psrc,ill}
  localparam logic [16:0] V_ZERO = 17'b0;
  localparam logic [16:0] V_F    = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] V_FW   = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] V_D    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] V_DILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] V_MA   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] V_MR   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] V_MWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] V_MW   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] V_EX   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] V_AWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] V_BR   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] V_J    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] V_IWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  multicycle_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read,
                mem_write, ir_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal_op};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    logic [3:0]  es [4] = '{4'd1, 4'd2, 4'd7, 4'd8};
    logic [16:0] eo [4] = '{V_F, V_D, V_EX, V_AWB};
    rst_n = 1'b0;
    op = 6'b000000;
    mem_ready = 1'b1;
    #12;
    total++;
    if (state !== 4'd0 || obs !== V_ZERO) begin
      bad++;
      $display("FAIL reset: state=%0d ctl=%b want 0/%b",
               state, obs, V_ZERO);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (state !== es[i] || obs !== eo[i]) begin
        bad++;
        $display("FAIL rtype[%0d]: state=%0d ctl=%b want %0d/%b",
                 i, state, obs, es[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    logic [5:0]  ops [8] = '{6'h23, 6'h23, 6'h23, 6'h23,
                             6'h23, 6'h23, 6'h23, 6'h23};
    logic        rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  es  [8] = '{4'd1, 4'd2, 4'd3, 4'd4,
                             4'd4, 4'd4, 4'd4, 4'd5};
    logic [16:0] eo  [8] = '{V_F, V_D, V_MA, V_MR,
                             V_MR, V_MR, V_MR, V_MWB};
    for (int i = 0; i < 8; i++) begin
      op = ops[i];
      mem_ready = rdy[i];
      #1;
      total++;
      if (state !== es[i] || obs !== eo[i]) begin
        bad++;
        $display("FAIL lw[%0d]: state=%0d ctl=%b want %0d/%b",
                 i, state, obs, es[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [3:0]  es [4] = '{4'd1, 4'd2, 4'd3, 4'd6};
    logic [16:0] eo [4] = '{V_F, V_D, V_MA, V_MW};
    op = 6'b101011;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (state !== es[i] || obs !== eo[i]) begin
        bad++;
        $display("FAIL sw[%0d]: state=%0d ctl=%b want %0d/%b",
                 i, state, obs, es[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0]  ops [6] = '{6'h04, 6'h04, 6'h04,
                             6'h02, 6'h02, 6'h02};
    logic [3:0]  es  [6] = '{4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd10};
    logic [16:0] eo  [6] = '{V_F, V_D, V_BR, V_F, V_D, V_J};
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = ops[i];
      #1;
      total++;
      if (state !== es[i] || obs !== eo[i]) begin
        bad++;
        $display("FAIL br_j[%0d]: state=%0d ctl=%b want %0d/%b",
                 i, state, obs, es[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_wait();
    logic        rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0]  es  [6] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd7, 4'd8};
    logic [16:0] eo  [6] = '{V_FW, V_FW, V_F, V_D, V_EX, V_AWB};
    op = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy[i];
      #1;
      total++;
      if (state !== es[i] || obs !== eo[i]) begin
        bad++;
        $display("FAIL fwait[%0d]: state=%0d ctl=%b want %0d/%b",
                 i, state, obs, es[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [5:0]  ops [6] = '{6'h3f, 6'h3f, 6'h00,
                             6'h00, 6'h00, 6'h00};
    logic [3:0]  es  [6] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd7, 4'd8};
    logic [16:0] eo  [6] = '{V_F, V_DILL, V_F, V_D, V_EX, V_AWB};
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = ops[i];
      #1;
      total++;
      if (state !== es[i] || obs !== eo[i]) begin
        bad++;
        $display("FAIL illegal[%0d]: state=%0d ctl=%b want %0d/%b",
                 i, state, obs, es[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi();
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    logic [3:0]  es [4] = '{4'd1, 4'd2, 4'd11, 4'd12};
    logic [16:0] eo [4] = '{V_F, V_D, V_MA, V_IWB};
`else
    logic [3:0]  es [4] = '{4'd1, 4'd2, 4'd1, 4'd2};
    logic [16:0] eo [4] = '{V_F, V_DILL, V_F, V_DILL};
`endif
    op = 6'b001000;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (state !== es[i] || obs !== eo[i]) begin
        bad++;
        $display("FAIL addi[%0d]: state=%0d ctl=%b want %0d/%b",
                 i, state, obs, es[i], eo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic        rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  es  [5] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6};
    logic [16:0] eo  [5] = '{V_F, V_D, V_MA, V_MW, V_MW};
    op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      #1;
      total++;
      if (state !== es[i] || obs !== eo[i]) begin
        bad++;
        $display("FAIL rmid[%0d]: state=%0d ctl=%b want %0d/%b",
                 i, state, obs, es[i], eo[i]);
      end
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || mem_write !== 1'b0 || obs !== V_ZERO) begin
      bad++;
      $display("FAIL async_rst: state=%0d ctl=%b want 0/%b",
               state, obs, V_ZERO);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (state !== 4'd1) begin
      bad++;
      $display("FAIL rst_release: state=%0d want 1", state);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_lw_wait();
    test_sw();
    test_branch_jump();
    test_fetch_wait();
    test_illegal();
    test_addi();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences every instruction through fetch / decode / execute / memory / writeback steps and produces all datapath enables and mux selects.
- Drives the 2-bit alu_op consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = use funct field.
- Waits on a memory ready handshake for every memory access.

Parameters:
- none (all encodings fixed in the shared package)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  opcode field from the instruction register; stable from DECODE until the next FETCH
- mem_ready  in  1  memory has completed the current read or write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (branch)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register write data select: 1 = MDR
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  to ALU control decoder
- pc_source  out  2  PC mux select: 00 = ALU, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010, addi = 001000.
- State encoding (4 bit): IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12.
- Reset: rst_n low forces state = IDLE immediately, regardless of clk, including mid-instruction. All outputs are 0 in IDLE.
- Outputs are Moore decodes of state, with two Mealy exceptions in FETCH. Any output not listed for a state is 0.
- IDLE: leaves to FETCH on the first clock after reset release.
- FETCH:
  - Outputs: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00, pc_write=mem_ready, ir_write=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_b=11, alu_op=00.
  - Next state: lw or sw -> MEMADR; R -> EXEC; beq -> BRANCH; j -> JUMP; addi -> ADDIEX (feature only).
  - Any other opcode -> FETCH, with illegal_op=1 during this DECODE cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD if lw, MEMWR if sw.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10. Goes to FETCH.
- Latency with mem_ready tied to 1, counted from FETCH back to FETCH: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Memory strobes stay asserted for the whole wait. mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- Unused encodings 13–15 go to IDLE on the next clock, with all outputs 0.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_ADDI_EN.
- Defined: DECODE sends addi to ADDIEX.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- Undefined: addi is illegal (illegal_op pulse, back to FETCH). Encodings 11 and 12 are treated as unused.

Decomposition:
- Shared package mc_pkg holds: opcode constants, state encodings, alu_op constants (ADD, SUB, FUNCT), alu_src_b constants, pc_source constants.
- One sub-module, mc_output_decode: purely combinational state (+ mem_ready) -> control word.
- The top level keeps the state register and next-state logic.

Test Plan:
- Release reset with op=000000 and mem_ready=1: states go 0,1,2,7,8,1. In EXEC alu_op=10; in ALUWB reg_write=1, reg_dst=1.
- lw with mem_ready low for 3 cycles in MEMRD: state holds 4 with mem_read=1, i_or_d=1 for 4 cycles. Then MEMWB gives reg_write=1, mem_to_reg=1.
- beq: in BRANCH, alu_op=01, pc_write_cond=1, pc_source=01, and the FSM returns to FETCH after 3 cycles. j: pc_write=1, pc_source=10.
- FETCH with mem_ready=0 for 2 cycles: pc_write=0 and ir_write=0 while waiting. Both go to 1 in the cycle mem_ready=1, then DECODE.
- op=111111: illegal_op=1 for exactly one cycle (in DECODE), next state FETCH. Separately, pull rst_n low mid-MEMWR: state=0 and mem_write=0 with no clock edge.
- op=001000 with the macro defined: 1,2,11,12,1 with reg_write=1 in ADDIWB. Without the macro: illegal_op pulse, then FETCH.
